// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate pipelined multiplier.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package approx_mult_pkg;

    // Width of one operand digit; sub-products are DIG x DIG.
    localparam int DIG = 4;

    // Run-time approximation level: number of sub-product LSBs cleared.
    typedef logic [1:0] lvl_t;

    // Bit position of sub-product (i,j) within the full product.
    function automatic int sub_weight(input int i, input int j);
        return DIG * (i + j);
    endfunction

    // Keep-mask for an 8-bit sub-product: the lvl lowest bits are cleared.
    function automatic logic [7:0] trunc_mask(input lvl_t lvl);
        return 8'hFF << lvl;
    endfunction

endpackage

// File: rtl/approx_lm4x4.sv
// 4x4 unsigned multiplier with optional LSB truncation of the 8-bit product.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module approx_lm4x4
    import approx_mult_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  lvl_t       i_lvl,
    input  logic       i_approx_en,
    output logic [7:0] o_p
);

    logic [7:0] w_full;

    assign w_full = {4'b0000, i_a} * {4'b0000, i_b};

    // Truncation only applies to digit pairs below the cut point.
    assign o_p = i_approx_en ? (w_full & trunc_mask(i_lvl)) : w_full;

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage approximate unsigned W x W multiplier built from 4x4 sub-products.
// Latency: 2 cycles input transfer to out_valid; 1 beat/cycle throughput.
// Backpressure: in_ready is combinational from out_ready; stalled stages hold.
// Optional: define APPROX_ADD_EN for a lower-part-OR final adder split at ADD_LSB.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int W       = 8,
    parameter int CUT     = 1,
    parameter int ADD_LSB = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  lvl_t           in_lvl,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_r,
    output logic           out_exact
);

    localparam int ND = W / DIG;
    localparam int NP = ND * ND;

    logic [7:0]     w_p [NP];
    logic           w_s1_exact;
    logic           w_s1_adv;
    logic           w_s2_adv;
    logic [2*W-1:0] w_sum;
    logic           w_add_exact;

    logic [7:0]     r_s1_p [NP];
    logic           r_s1_valid;
    logic           r_s1_exact;
    logic           r_out_valid;
    logic [2*W-1:0] r_out_r;
    logic           r_out_exact;

    assign w_s2_adv   = !r_out_valid || out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign in_ready   = w_s1_adv;
    assign w_s1_exact = (in_lvl == 2'd0) || (CUT == 0);

    // One sub-product per digit pair; pairs with i+j below CUT may be truncated.
    for (genvar gi = 0; gi < ND; gi++) begin : g_row
        for (genvar gj = 0; gj < ND; gj++) begin : g_col
            approx_lm4x4 u_lm (
                .i_a        (in_a[DIG*gi +: DIG]),
                .i_b        (in_b[DIG*gj +: DIG]),
                .i_lvl      (in_lvl),
                .i_approx_en((gi + gj) < CUT),
                .o_p        (w_p[gi*ND + gj])
            );
        end
    end

    // S1: capture sub-products and the exact flag when the stage may advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_exact <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_p     <= w_p;
                r_s1_exact <= w_s1_exact;
            end
        end
    end

`ifdef APPROX_ADD_EN
    logic [2*W-1:0]     w_term;
    logic [2*W-1:0]     w_hi;
    logic [2*W-1:0]     w_lo_ext;
    logic [ADD_LSB-1:0] w_lo;
    logic               w_overlap;

    // Lower-part-OR adder: high parts add, low parts OR, no carry across the split.
    always_comb begin
        w_term    = '0;
        w_hi      = '0;
        w_lo      = '0;
        w_overlap = 1'b0;
        for (int k = 0; k < NP; k++) begin
            w_term    = {{(2*W-8){1'b0}}, r_s1_p[k]} << sub_weight(k / ND, k % ND);
            w_overlap = w_overlap | (|(w_lo & w_term[ADD_LSB-1:0]));
            w_lo      = w_lo | w_term[ADD_LSB-1:0];
            w_hi      = w_hi + (w_term >> ADD_LSB);
        end
        w_lo_ext              = '0;
        w_lo_ext[ADD_LSB-1:0] = w_lo;
        w_sum                 = (w_hi << ADD_LSB) | w_lo_ext;
        w_add_exact           = !w_overlap;
    end
`else
    // Exact adder tree over all shifted sub-products, modulo 2^(2W).
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NP; k++) begin
            w_sum = w_sum + ({{(2*W-8){1'b0}}, r_s1_p[k]} << sub_weight(k / ND, k % ND));
        end
        w_add_exact = 1'b1;
    end
`endif

    // S2: register the summed product; held stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_r     <= '0;
            r_out_exact <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_r     <= w_sum;
                r_out_exact <= r_s1_exact && w_add_exact;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_r     = r_out_r;
    assign out_exact = r_out_exact;

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
Parametrised, pipelined approximate unsigned multiplier, built from a W/4 × W/4 array of 4x4 sub-products.
Sub-products whose digit weight falls below a cut point are truncated by a run-time approximation level. Sub-products are then summed by an exact (or optionally lower-part-OR) adder.
Valid/ready handshakes on input and output, so it drops into streaming datapaths as a replacement for the fixed 8x8 combinational multipliers.

Parameters:
W, 8, operand width; multiple of 4, legal range 8..32; ND = W/4 digits per operand.
CUT, 1, sub-product (i,j) is approximable iff i+j < CUT; CUT=0 means always exact.
ADD_LSB, 8, width of the lower OR-part when APPROX_ADD_EN is defined; 1..2W-1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat.
in_a  in  W  multiplicand, unsigned.
in_b  in  W  multiplier, unsigned.
in_lvl  in  2  approximation level for this beat; 0 = exact.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_r  out  2W  product.
out_exact  out  1  1 if in_lvl was 0 or CUT=0 for this beat.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_a, in_b and in_lvl are sampled only on an input transfer.
- Stage S1 (registered), per sub-product:
  - p(i,j) = a_digit(i) * b_digit(j), 8 bits.
  - If i+j < CUT, bits [in_lvl-1:0] of p(i,j) are forced to 0.
  - All ND² sub-products, the exact flag and s1_valid are registered.
- Stage S2 (registered): out_r = Σ p(i,j) << 4(i+j). The sum is exact and modulo 2^(2W); it cannot overflow.
- Latency: 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Flow control:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, a combinational path from out_ready.
  - Stalled stages hold their data unchanged.
  - out_r and out_exact stay stable while out_valid is high and out_ready is low.
- Reset values: s1_valid=0, out_valid=0, out_r=0, out_exact=0. in_ready is 1 in the cycle after reset.
- Reset mid-operation: all in-flight beats are discarded; no output is produced for them.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts, advances and emits in the same cycle, with no bubble.
- in_lvl=3 truncates 3 LSBs. The truncation never touches sub-products with i+j >= CUT.

Optional Feature:
APPROX_ADD_EN:
- Defined: the S2 adder is a lower-part-OR adder.
  - Each shifted term is split at ADD_LSB.
  - Result high part = Σ(term >> ADD_LSB).
  - Result low part = bitwise OR of term[ADD_LSB-1:0].
  - No carry propagates from the low part into the high part.
  - out_exact additionally requires that no two terms have overlapping set bits in the low part.
- Undefined: exact adder as above; ADD_LSB is ignored.

Decomposition:
- Package approx_mult_pkg holds:
  - the lvl_t 2-bit typedef;
  - the digit width constant DIG=4;
  - the function sub_weight(i,j) returning 4*(i+j);
  - the function trunc_mask(lvl) returning the 8-bit mask.
- One sub-module, approx_lm4x4: combinational 4x4 multiplier with lvl and enable-approx inputs. It is instantiated ND² times by generate in S1.

Test Plan:
- W=8, CUT=1, lvl=0: A=0xFF, B=0xFF → out_r=0xFE01, out_exact=1, out_valid 2 cycles after the transfer.
- W=8, CUT=1, lvl=2: A=0xFF, B=0xFF → out_r=0xFE00, out_exact=0. A=0x03, B=0x05 → out_r=0x000C.
- W=16, CUT=0, lvl=3: random 1000 beats → out_r equals the exact product on every beat; out_exact=1.
- Backpressure: stream 10 beats with out_ready toggling 1/0 each cycle → all 10 results are in order with no loss or duplication; out_r is stable during stalls; in_ready goes low once both stages are full.
- Reset: assert rst for 1 cycle with 2 beats in flight → out_valid=0 next cycle and stays 0 until new input; in_ready=1.
- APPROX_ADD_EN, W=8, ADD_LSB=8, lvl=0: A=0xFF, B=0xFF → out_r=0xFDF1, out_exact=0.
